// File: rtl/mem_arbiter.sv
// Shares one memory read port and one write port among instruction-fetch, load and store
// requesters, one transaction at a time. Define MEM_ARB_RR_EN for round-robin grants.
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif

module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned ARB_WIDTH   = `COMMON_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    // instruction fetch
    input  logic                 if_en_i,
    input  logic [ARB_WIDTH-1:0] if_addr_i,
    input  logic [2:0]           if_byte_num_i,
    output logic [ARB_WIDTH-1:0] if_data_o,
    output logic                 if_done_o,
    // load
    input  logic                 ld_en_i,
    input  logic [ARB_WIDTH-1:0] ld_addr_i,
    input  logic [2:0]           ld_byte_num_i,
    output logic [ARB_WIDTH-1:0] ld_data_o,
    output logic                 ld_done_o,
    // store
    input  logic                 st_en_i,
    input  logic [ARB_WIDTH-1:0] st_addr_i,
    input  logic [ARB_WIDTH-1:0] st_data_i,
    input  logic [2:0]           st_byte_num_i,
    output logic                 st_done_o,
    // memory read port
    output logic                 rd_en_o,
    output logic [ARB_WIDTH-1:0] rd_addr_o,
    output logic [2:0]           rd_byte_num_o,
    input  logic [ARB_WIDTH-1:0] rd_data_i,
    // memory write port
    output logic                 wr_en_o,
    output logic [ARB_WIDTH-1:0] wr_addr_o,
    output logic [ARB_WIDTH-1:0] wr_data_o,
    output logic [2:0]           wr_byte_num_o
);

    localparam logic [1:0] ID_IF = 2'd0;
    localparam logic [1:0] ID_LD = 2'd1;
    localparam logic [1:0] ID_ST = 2'd2;
    localparam logic [3:0] LAT   = 4'(MEM_LATENCY);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               state_q, state_d;
    logic [1:0]           id_q, id_d;
    logic [ARB_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]           byte_q, byte_d;
    logic [ARB_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [ARB_WIDTH-1:0] if_data_q, if_data_d;
    logic [ARB_WIDTH-1:0] ld_data_q, ld_data_d;

    logic [2:0]           req_vec;
    logic                 any_req;
    logic [1:0]           win_id;
    logic                 byte_ok;
    logic [ARB_WIDTH-1:0] rd_word;
    logic                 resp_act;
    logic [2:0]           done_vec;

    assign req_vec = {st_en_i, ld_en_i, if_en_i};
    assign any_req = |req_vec;
    assign byte_ok = (byte_q == 3'd1) || (byte_q == 3'd2) || (byte_q == 3'd4);

`ifdef MEM_ARB_RR_EN
    // rr_ptr_q names the requester that gets first look at the next arbitration
    logic [1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        win_id = ID_IF;
        case (rr_ptr_q)
            ID_LD:   win_id = req_vec[1] ? ID_LD : (req_vec[2] ? ID_ST : ID_IF);
            ID_ST:   win_id = req_vec[2] ? ID_ST : (req_vec[0] ? ID_IF : ID_LD);
            default: win_id = req_vec[0] ? ID_IF : (req_vec[1] ? ID_LD : ID_ST);
        endcase
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == S_IDLE && any_req) begin
            rr_ptr_d = (win_id == ID_ST) ? ID_IF : win_id + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= ID_IF;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        if (req_vec[2]) begin
            win_id = ID_ST;
        end else if (req_vec[1]) begin
            win_id = ID_LD;
        end else begin
            win_id = ID_IF;
        end
    end
`endif

    // Zero-extend the returned word to the requested width; illegal sizes return 0.
    always_comb begin
        case (byte_q)
            3'd1:    rd_word = ARB_WIDTH'(rd_data_i[7:0]);
            3'd2:    rd_word = ARB_WIDTH'(rd_data_i[15:0]);
            3'd4:    rd_word = rd_data_i;
            default: rd_word = '0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (cnt_q <= 4'd1) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        rd_en_o  = 1'b0;
        wr_en_o  = 1'b0;
        resp_act = 1'b0;
        case (state_q)
            S_ISSUE: begin
                if (byte_ok) begin
                    if (id_q == ID_ST) begin
                        wr_en_o = 1'b1;
                    end else begin
                        rd_en_o = 1'b1;
                    end
                end
            end
            S_RESP:  resp_act = 1'b1;
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_done
            assign done_vec[gi] = resp_act && (id_q == 2'(gi));
        end
    endgenerate

    assign if_done_o = done_vec[ID_IF];
    assign ld_done_o = done_vec[ID_LD];
    assign st_done_o = done_vec[ID_ST];

    // Transaction datapath: fields are frozen at grant so later input changes are ignored.
    always_comb begin
        id_d      = id_q;
        addr_d    = addr_q;
        byte_d    = byte_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        if_data_d = if_data_q;
        ld_data_d = ld_data_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    id_d = win_id;
                    case (win_id)
                        ID_ST: begin
                            addr_d  = st_addr_i;
                            byte_d  = st_byte_num_i;
                            wdata_d = st_data_i;
                        end
                        ID_LD: begin
                            addr_d  = ld_addr_i;
                            byte_d  = ld_byte_num_i;
                            wdata_d = '0;
                        end
                        default: begin
                            addr_d  = if_addr_i;
                            byte_d  = if_byte_num_i;
                            wdata_d = '0;
                        end
                    endcase
                end
            end
            S_ISSUE: cnt_d = LAT;
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    if (id_q == ID_IF) begin
                        if_data_d = rd_word;
                    end else if (id_q == ID_LD) begin
                        ld_data_d = rd_word;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q      <= ID_IF;
            addr_q    <= '0;
            byte_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            if_data_q <= '0;
            ld_data_q <= '0;
        end else begin
            id_q      <= id_d;
            addr_q    <= addr_d;
            byte_q    <= byte_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            if_data_q <= if_data_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign if_data_o     = if_data_q;
    assign ld_data_o     = ld_data_q;
    assign rd_addr_o     = addr_q;
    assign rd_byte_num_o = byte_q;
    assign wr_addr_o     = addr_q;
    assign wr_data_o     = wdata_q;
    assign wr_byte_num_o = byte_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_LATENCY, default 1: cycles spent in WAIT after the memory strobe, range 1..15.
REQ-002 Parameter ARB_WIDTH, default 32: width of every address and data bus, equal to `COMMON_WIDTH.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 if_en, if_addr[ARB_WIDTH], if_byte_num[3]  input: instruction-fetch read request; if_data[ARB_WIDTH], if_done  output.
REQ-006 ld_en, ld_addr[ARB_WIDTH], ld_byte_num[3]  input: load read request; ld_data[ARB_WIDTH], ld_done  output.
REQ-007 st_en, st_addr[ARB_WIDTH], st_data[ARB_WIDTH], st_byte_num[3]  input: store request; st_done  output.
REQ-008 rd_en, rd_addr[ARB_WIDTH], rd_byte_num[3]  output; rd_data[ARB_WIDTH]  input: memory read port (unit_read side).
REQ-009 wr_en, wr_addr[ARB_WIDTH], wr_data[ARB_WIDTH], wr_byte_num[3]  output: memory write port (unit_write side); memory done is not used.

Function
REQ-010 States: IDLE, ISSUE, WAIT, RESP; one transaction in flight at a time.
REQ-011 IDLE: sample if_en/ld_en/st_en at posedge; if any is high, latch the winner's id, addr, byte_num, data, then go to ISSUE; otherwise stay in IDLE.
REQ-012 Default fixed priority: st > ld > if.
REQ-013 ISSUE (exactly 1 cycle): drive rd_en=1 (read winner) or wr_en=1 (store winner) with the latched fields; go to WAIT with counter=MEM_LATENCY.
REQ-014 rd_en and wr_en are never both 1 in any cycle; both are 0 in every state other than ISSUE.
REQ-015 WAIT: decrement counter each cycle; on the cycle the counter reaches 1, capture rd_data into the winner's data register (reads only), then go to RESP.
REQ-016 Captured data: byte_num 1 -> {24'b0, rd_data[7:0]}; 2 -> {16'b0, rd_data[15:0]}; 4 -> rd_data[31:0].
REQ-017 RESP (exactly 1 cycle): pulse the winner's done=1; all other done outputs stay 0; then go to IDLE.
REQ-018 if_data/ld_data hold their last captured value until that requester's next read completes.
REQ-019 Latency: request sampled at edge 0 -> done high in cycle 2+MEM_LATENCY; minimum issue interval 3+MEM_LATENCY cycles.
REQ-020 Illegal byte_num (not 1, 2, 4): no rd_en/wr_en strobe, data register loaded with 0, done still pulsed on the normal schedule.
REQ-021 Requests are sampled only in IDLE; changes to requester inputs after latching have no effect on the transaction in flight.
REQ-022 A requester that drops en mid-transaction still receives its done pulse.
REQ-023 Requesters deassert en in the cycle after their done pulse; an en still held high when the arbiter returns to IDLE is treated as a new request.

Reset
REQ-024 On rst: state IDLE; all done, rd_en, wr_en = 0; all addr, data and byte_num outputs = 0; if_data and ld_data = 0; round-robin pointer = if.
REQ-025 Reset asserted mid-transaction aborts it immediately: no strobe and no done for the aborted request.
REQ-026 First arbitration after rst deasserts happens at the first posedge with rst low.

Configuration
REQ-027 Macro MEM_ARB_RR_EN defined: round-robin priority; the search starts at the requester after the last winner, in the order if -> ld -> st -> if.
REQ-028 Macro MEM_ARB_RR_EN undefined: fixed priority per REQ-012; the round-robin pointer is not built.

Verification
REQ-029 All three en high in the same cycle, fixed priority, MEM_LATENCY=1 -> grants in the order st, ld, if; st_done at cycle 3; wr_en never overlaps rd_en.
REQ-030 ld read addr=0x10, byte_num=2, memory bytes 0x34,0x12 at 0x10/0x11 -> ld_data=0x00001234, ld_done single pulse, if_data unchanged.
REQ-031 MEM_ARB_RR_EN defined, if_en and ld_en both held continuously for 4 transactions -> grants alternate if, ld, if, ld.
REQ-032 if_byte_num=3 -> no rd_en pulse, if_data=0, if_done pulses at cycle 2+MEM_LATENCY.
REQ-033 rst asserted during WAIT of a store -> st_done never pulses, wr_en=0, state IDLE; a new if request after reset completes normally.
REQ-034 MEM_LATENCY=4, single if read -> rd_en high only in cycle 1, if_done high in cycle 6, back in IDLE in cycle 7.
